ripple_carry_adder: RTL and testbench



---
 rtl/ripple_carry_adder_pkg.sv | 17 +
 rtl/ripple_carry_adder_full_adder.sv | 24 ++
 rtl/ripple_carry_adder.sv | 69 ++++++
 tb/tb_ripple_carry_adder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ripple_carry_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ripple_carry_adder_pkg
// Description : Shared constants and helpers for the ripple-carry adder.
// Revision    : 1.0 - initial release
// ============================================================================
package ripple_carry_adder_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Two's-complement overflow from the carries into and out of the MSB.
    function automatic logic signed_overflow(input logic c_msb_in, input logic c_msb_out);
        return c_msb_in ^ c_msb_out;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ripple_carry_adder_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : 1-bit full adder, one link of the ripple-carry chain.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder
    import ripple_carry_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic w_p;

    assign w_p   = a ^ b;
    assign s     = w_p ^ c_in;
    assign c_out = (a & b) | (c_in & w_p);

endmodule
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module      : ripple_carry_adder
// Description : xlen-bit ripple-carry adder with combinational and registered
//               result, carry-out and signed-overflow outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int xlen = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [xlen-1:0] a,
    input  logic [xlen-1:0] b,
    input  logic            carry_in,
    output logic [xlen-1:0] sum,
    output logic            carry_out,
    output logic            overflow,
    output logic [xlen-1:0] sum_q,
    output logic            carry_out_q,
    output logic            overflow_q
);

    // carry[i] is the carry into bit i; carry[xlen] leaves the MSB.
    logic [xlen:0] w_carry;

    logic [xlen-1:0] sum_d;
    logic            carry_out_d;
    logic            overflow_d;

    assign w_carry[0] = carry_in;

    genvar gi;
    generate
        for (gi = 0; gi < xlen; gi++) begin : g_bit
            full_adder u_fa (
                .a     (a[gi]),
                .b     (b[gi]),
                .c_in  (w_carry[gi]),
                .s     (sum[gi]),
                .c_out (w_carry[gi+1])
            );
        end
    endgenerate

    assign carry_out = w_carry[xlen];
    assign overflow  = signed_overflow(w_carry[xlen-1], w_carry[xlen]);

    always_comb begin
        sum_d       = sum;
        carry_out_d = carry_out;
        overflow_d  = overflow;
        if (rst) begin
            sum_d       = '0;
            carry_out_d = 1'b0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        sum_q       <= sum_d;
        carry_out_q <= carry_out_d;
        overflow_q  <= overflow_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ripple_carry_adder
// Description : Scoreboard bench for 64-bit and 1-bit ripple-carry adders.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_carry_adder;

    typedef struct {
        string       name;
        logic        r;
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        s1;
        logic        co1;
        logic        ov1;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a, b;
    logic        cin;
    logic [63:0] sum, sum_q;
    logic        co, ov, co_q, ov_q;
    logic [0:0]  a1, b1, sum1, sum1_q;
    logic        cin1, co1, ov1, co1_q, ov1_q;

    item_t q[$];
    int    n_total = 0;
    int    n_pass  = 0;

    always #5 clk = ~clk;

    ripple_carry_adder #(.xlen(64)) u_dut64 (
        .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(cin),
        .sum(sum), .carry_out(co), .overflow(ov),
        .sum_q(sum_q), .carry_out_q(co_q), .overflow_q(ov_q)
    );

    ripple_carry_adder #(.xlen(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .carry_in(cin1),
        .sum(sum1), .carry_out(co1), .overflow(ov1),
        .sum_q(sum1_q), .carry_out_q(co1_q), .overflow_q(ov1_q)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Applies one operand set to both adders and queues the expected response.
    // Directed callers pass hand-computed results; the 1-bit side uses a model.
    task automatic drive(input string name, input logic r, input logic [63:0] va,
                         input logic [63:0] vb, input logic vc, input logic [63:0] es,
                         input logic eco, input logic eov);
        item_t it;
        logic [1:0] t1;
        @(posedge clk);
        #1;
        rst  = r;
        a    = va;
        b    = vb;
        cin  = vc;
        a1   = 1'($urandom_range(0, 1));
        b1   = 1'($urandom_range(0, 1));
        cin1 = 1'($urandom_range(0, 1));
        t1   = 2'(a1) + 2'(b1) + 2'(cin1);
        it.name = name;
        it.r    = r;
        it.s    = es;
        it.co   = eco;
        it.ov   = eov;
        it.s1   = t1[0];
        it.co1  = t1[1];
        it.ov1  = (a1 == b1) && (t1[0] != a1[0]);
        q.push_back(it);
    endtask

    task automatic drive_rand(input string name);
        logic [63:0] ra, rb, rs;
        logic        rc;
        logic [64:0] t;
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
        rc = 1'($urandom_range(0, 1));
        t  = {1'b0, ra} + {1'b0, rb} + 65'(rc);
        rs = t[63:0];
        drive(name, 1'b0, ra, rb, rc, rs, t[64], (ra[63] == rb[63]) && (rs[63] != ra[63]));
    endtask

    // Monitor: comb outputs checked mid-cycle; registers checked one cycle on.
    initial begin : monitor
        item_t cur, prev;
        bit    have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (have_prev) begin
                check({prev.name, " sum_q"},  sum_q,        prev.r ? 64'd0 : prev.s);
                check({prev.name, " co_q"},   64'(co_q),    prev.r ? 64'd0 : 64'(prev.co));
                check({prev.name, " ov_q"},   64'(ov_q),    prev.r ? 64'd0 : 64'(prev.ov));
                check({prev.name, " sum1_q"}, 64'(sum1_q),  prev.r ? 64'd0 : 64'(prev.s1));
                check({prev.name, " co1_q"},  64'(co1_q),   prev.r ? 64'd0 : 64'(prev.co1));
                check({prev.name, " ov1_q"},  64'(ov1_q),   prev.r ? 64'd0 : 64'(prev.ov1));
            end
            if (q.size() > 0) begin
                cur = q.pop_front();
                check({cur.name, " sum"},  sum,        cur.s);
                check({cur.name, " co"},   64'(co),    64'(cur.co));
                check({cur.name, " ov"},   64'(ov),    64'(cur.ov));
                check({cur.name, " sum1"}, 64'(sum1),  64'(cur.s1));
                check({cur.name, " co1"},  64'(co1),   64'(cur.co1));
                check({cur.name, " ov1"},  64'(ov1),   64'(cur.ov1));
                prev      = cur;
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    initial begin : driver
        rst = 1'b1; a = '0; b = '0; cin = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        drive("rst0",    1'b1, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        drive("rst1",    1'b1, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        drive("zero",    1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        drive("wrap",    1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
        drive("sub",     1'b0, 64'd53, ~64'd48, 1'b1, 64'd5, 1'b1, 1'b0);
        drive("sovf",    1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
              64'h8000_0000_0000_0000, 1'b0, 1'b1);
        drive("borrow",  1'b0, 64'd48, ~64'd53, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0);
        drive("negovf",  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        drive("sub2",    1'b0, 64'd53, ~64'd48, 1'b1, 64'd5, 1'b1, 1'b0);
        drive("midrst",  1'b1, 64'd53, ~64'd48, 1'b1, 64'd5, 1'b1, 1'b0);
        drive("resume",  1'b0, 64'd53, ~64'd48, 1'b1, 64'd5, 1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) drive_rand("rand");
        repeat (3) @(posedge clk);
        n_total++;
        if (q.size() != 0)
            $display("FAIL drain: got %0d queued items expected 0", q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
